// File: rtl/exibidor_bomba_if.sv
// Interface between the countdown timer and the display/alarm stage.
// The master side drives the timer digits and the time-up flag.
// The slave side drives the four 7-segment displays and the buzzer.
interface exibidor_bomba_if;
   logic [3:0] DECIMOS;
   logic [3:0] SEGUNDOS_UNIDADE;
   logic [3:0] SEGUNDOS_DECIMOS;
   logic [3:0] MINUTOS;
   logic       TEMPO_ACABOU;
   logic [6:0] HEX0;
   logic [6:0] HEX1;
   logic [6:0] HEX2;
   logic [6:0] HEX3;
   logic       BUZZER;

   modport master (
      output DECIMOS, SEGUNDOS_UNIDADE, SEGUNDOS_DECIMOS, MINUTOS, TEMPO_ACABOU,
      input  HEX0, HEX1, HEX2, HEX3, BUZZER
   );

   modport slave (
      input  DECIMOS, SEGUNDOS_UNIDADE, SEGUNDOS_DECIMOS, MINUTOS, TEMPO_ACABOU,
      output HEX0, HEX1, HEX2, HEX3, BUZZER
   );
endinterface

// File: rtl/exibidor_bomba.sv
// Display and alarm stage for the countdown timer.
// Stage 1 captures the timer digits. Stage 2 registers the state, the
// active-low 7-segment patterns and the buzzer. Three modes exist:
//   NORMAL   - the digits are shown and the buzzer is silent.
//   ALERTA   - the last 10 s: the buzzer beeps for BEEP_CYCLES on every
//              seconds change.
//   EXPLODIU - time is up: all digits blink and the buzzer stays on.
module exibidor_bomba #(
   parameter int unsigned BLINK_HALF  = 25_000_000,
   parameter int unsigned BEEP_CYCLES = 5_000_000
) (
   input  logic             CLOCK,
   input  logic             RESET,
   exibidor_bomba_if.slave  bus
);

   // 64-bit arithmetic so that BEEP_CYCLES = 2^32-1 does not wrap in the +1
   localparam int BLW = $clog2(longint'(BLINK_HALF) + 1);
   localparam int BPW = $clog2(longint'(BEEP_CYCLES) + 1);
   localparam logic [BLW-1:0] BL_LAST = BLW'(BLINK_HALF - 1);
   localparam logic [BPW-1:0] BP_LOAD = BPW'(BEEP_CYCLES);
   localparam logic [6:0]     SEG_OFF = 7'b1111111;

   typedef enum logic [1:0] {NORMAL, ALERTA, EXPLODIU} state_t;

   // BCD to active-low segments, bit0=a .. bit6=g; codes 10..15 show a dash
   function automatic logic [6:0] f_dec(input logic [3:0] d);
      case (d)
         4'd0:    f_dec = 7'b1000000;
         4'd1:    f_dec = 7'b1111001;
         4'd2:    f_dec = 7'b0100100;
         4'd3:    f_dec = 7'b0110000;
         4'd4:    f_dec = 7'b0011001;
         4'd5:    f_dec = 7'b0010010;
         4'd6:    f_dec = 7'b0000010;
         4'd7:    f_dec = 7'b1111000;
         4'd8:    f_dec = 7'b0000000;
         4'd9:    f_dec = 7'b0010000;
         default: f_dec = 7'b0111111;
      endcase
   endfunction

   // stage-1 sample
   logic [3:0]     r_s_dec, r_s_su, r_s_sd, r_s_min, r_s_su_prev;
   logic           r_s_tempo;
   // [0]: current sample is valid, [1]: previous sample is valid too
   logic [1:0]     r_vld_pipe;

   // stage-2 state
   state_t         r_state, w_state_nxt;
   logic [BLW-1:0] r_blink_cnt, w_blink_nxt;
   logic           r_phase, w_phase_nxt;
   logic [BPW-1:0] r_beep_cnt, w_beep_nxt;
   logic [6:0]     r_hex0, r_hex1, r_hex2, r_hex3;
   logic [6:0]     w_hex0, w_hex1, w_hex2, w_hex3;
   logic           r_buzzer, w_buzzer_nxt, w_blank;

   // capture the timer outputs and remember the previous seconds units
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_s_dec     <= '0;
         r_s_su      <= '0;
         r_s_sd      <= '0;
         r_s_min     <= '0;
         r_s_tempo   <= 1'b0;
         r_s_su_prev <= '0;
         r_vld_pipe  <= '0;
      end else begin
         r_s_dec     <= bus.DECIMOS;
         r_s_su      <= bus.SEGUNDOS_UNIDADE;
         r_s_sd      <= bus.SEGUNDOS_DECIMOS;
         r_s_min     <= bus.MINUTOS;
         r_s_tempo   <= bus.TEMPO_ACABOU;
         r_s_su_prev <= r_s_su;
         r_vld_pipe  <= {r_vld_pipe[0], 1'b1};
      end
   end

   // state register; held at reset until the first valid sample exists
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET)              r_state <= NORMAL;
      else if (r_vld_pipe[0]) r_state <= w_state_nxt;
   end

   // next state, blink/beep counters and the output patterns
   always_comb begin
      w_state_nxt  = NORMAL;
      w_blink_nxt  = '0;
      w_phase_nxt  = 1'b1;
      w_beep_nxt   = '0;
      w_buzzer_nxt = 1'b0;
      w_blank      = 1'b0;

      if (r_s_tempo)
         w_state_nxt = EXPLODIU;
      else if (r_s_min == 4'd0 && r_s_sd == 4'd0)
         w_state_nxt = ALERTA;

      // blink runs only while staying in EXPLODIU; entry restarts at on/0
      if (w_state_nxt == EXPLODIU && r_state == EXPLODIU) begin
         if (r_blink_cnt == BL_LAST) begin
            w_blink_nxt = '0;
            w_phase_nxt = ~r_phase;
         end else begin
            w_blink_nxt = r_blink_cnt + BLW'(1);
            w_phase_nxt = r_phase;
         end
      end

      // the beep reloads on every units change in ALERTA, so a retrigger has no gap
      if (w_state_nxt == ALERTA) begin
         if (r_vld_pipe[1] && r_s_su != r_s_su_prev)
            w_beep_nxt = BP_LOAD;
         else if (r_beep_cnt != '0)
            w_beep_nxt = r_beep_cnt - BPW'(1);
      end

      w_buzzer_nxt = (w_state_nxt == EXPLODIU) ||
                     (w_state_nxt == ALERTA && w_beep_nxt != '0);
      w_blank      = (w_state_nxt == EXPLODIU) && !w_phase_nxt;

      w_hex0 = w_blank ? SEG_OFF : f_dec(r_s_dec);
      w_hex1 = w_blank ? SEG_OFF : f_dec(r_s_su);
      w_hex2 = w_blank ? SEG_OFF : f_dec(r_s_sd);
      w_hex3 = w_blank ? SEG_OFF : f_dec(r_s_min);
   end

   // stage-2 registers; outputs stay blank until a valid sample arrives
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         r_blink_cnt <= '0;
         r_phase     <= 1'b1;
         r_beep_cnt  <= '0;
         r_hex0      <= SEG_OFF;
         r_hex1      <= SEG_OFF;
         r_hex2      <= SEG_OFF;
         r_hex3      <= SEG_OFF;
         r_buzzer    <= 1'b0;
      end else if (r_vld_pipe[0]) begin
         r_blink_cnt <= w_blink_nxt;
         r_phase     <= w_phase_nxt;
         r_beep_cnt  <= w_beep_nxt;
         r_hex0      <= w_hex0;
         r_hex1      <= w_hex1;
         r_hex2      <= w_hex2;
         r_hex3      <= w_hex3;
         r_buzzer    <= w_buzzer_nxt;
      end
   end

   assign bus.HEX0   = r_hex0;
   assign bus.HEX1   = r_hex1;
   assign bus.HEX2   = r_hex2;
   assign bus.HEX3   = r_hex3;
   assign bus.BUZZER = r_buzzer;

endmodule
